// File: rtl/link_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// link_ctrl : board-link sequencer (arbitrate, launch tx, await echo-ack, retry)
// Optional LINK_STATS_EN adds frames_sent / retries_total counters.
// Revision  : 1.0
// ---------------------------------------------------------------------------
module link_ctrl #(
  parameter int TIMEOUT_CYCLES = 6500000,
  parameter int MAX_RETRY      = 3,
  parameter int BUS_W          = 162
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             req_move,
  input  logic             req_btn,
  input  logic [BUS_W-1:0] board_bus,
  input  logic             tx_busy,
  output logic             tx_trigger,
  output logic [BUS_W-1:0] tx_val,
  input  logic             rx_ready,
  input  logic [BUS_W-1:0] rx_data,
  output logic [BUS_W-1:0] rx_board,
  output logic             rx_board_valid,
  output logic             ack_ok,
  output logic             link_busy,
  output logic             link_err
`ifdef LINK_STATS_EN
  ,
  output logic [15:0]      frames_sent,
  output logic [15:0]      retries_total
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_FAIL = 3'd4;

  logic [2:0]    state, state_nxt;
  logic          pend_move, pend_btn, pend_echo, btn_prev;
  logic          send_first, frame_echo;
  logic [TW-1:0] timer;
  logic [RW-1:0] retry;
  logic          ack_hit, rx_fwd, timer_done, retry_go;
  logic          grant_echo, grant_move, grant_btn, grant_any;

  always_comb begin
    ack_hit    = rx_ready && (state == S_WAIT) && (rx_data == tx_val);
    rx_fwd     = rx_ready && !ack_hit;
    timer_done = (state == S_WAIT) && (timer == TIMER_LAST) && !ack_hit;
    retry_go   = timer_done && (retry < RETRY_LAST);
    grant_echo = (state == S_IDLE) && pend_echo;
    grant_move = (state == S_IDLE) && !pend_echo && pend_move;
    grant_btn  = (state == S_IDLE) && !pend_echo && !pend_move && pend_btn;
    grant_any  = grant_echo || grant_move || grant_btn;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (grant_any) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_SEND;
      // The serializer may not have raised busy yet on the first SEND cycle.
      S_SEND: if (!send_first && !tx_busy) state_nxt = frame_echo ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (ack_hit)       state_nxt = S_IDLE;
        else if (retry_go) state_nxt = S_LOAD;
        else if (timer_done) state_nxt = S_FAIL;
      end
      S_FAIL: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_trigger = (state == S_LOAD);
    link_busy  = (state != S_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pend_move      <= 1'b0;
      pend_btn       <= 1'b0;
      pend_echo      <= 1'b0;
      btn_prev       <= 1'b0;
      send_first     <= 1'b0;
      frame_echo     <= 1'b0;
      timer          <= '0;
      retry          <= '0;
      tx_val         <= '0;
      rx_board       <= '0;
      rx_board_valid <= 1'b0;
      ack_ok         <= 1'b0;
      link_err       <= 1'b0;
    end else begin
      btn_prev   <= req_btn;
      // A fresh request in the grant cycle survives the grant's clear.
      pend_move  <= req_move || (pend_move && !grant_move);
      pend_btn   <= (req_btn && !btn_prev) || (pend_btn && !grant_btn);
      pend_echo  <= rx_fwd || (pend_echo && !grant_echo);
      send_first <= (state == S_LOAD);
      if (grant_any) begin
        frame_echo <= grant_echo;
        tx_val     <= grant_echo ? rx_board : board_bus;
      end
      rx_board_valid <= rx_fwd;
      if (rx_fwd) rx_board <= rx_data;
      ack_ok <= ack_hit;
      if (state == S_WAIT) timer <= timer + 1'b1;
      else                 timer <= '0;
      if (ack_hit || state == S_FAIL) retry <= '0;
      else if (retry_go)              retry <= retry + 1'b1;
      if (ack_hit)               link_err <= 1'b0;
      else if (state == S_FAIL)  link_err <= 1'b1;
    end
  end

`ifdef LINK_STATS_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      frames_sent   <= '0;
      retries_total <= '0;
    end else begin
      if (state == S_LOAD && frames_sent != 16'hFFFF) frames_sent <= frames_sent + 16'd1;
      if (retry_go && retries_total != 16'hFFFF)      retries_total <= retries_total + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_link_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_link_ctrl : directed bench for link_ctrl (TIMEOUT_CYCLES=100, MAX_RETRY=2)
// Revision     : 1.0
// ---------------------------------------------------------------------------
module tb_link_ctrl;
  localparam int BW       = 162;
  localparam int BUSY_CYC = 20;
  // One attempt spans LOAD (1) + SEND (20 busy cycles) + WAIT_ACK (100).
  localparam int ATTEMPT  = 121;

  logic          clk_in = 1'b0, rst_in = 1'b1;
  logic          req_move = 1'b0, req_btn = 1'b0, rx_ready = 1'b0;
  logic          tx_busy;
  logic [BW-1:0] board_bus = '0, rx_data = '0;
  logic          tx_trigger, rx_board_valid, ack_ok, link_busy, link_err;
  logic [BW-1:0] tx_val, rx_board;
`ifdef LINK_STATS_EN
  logic [15:0]   frames_sent, retries_total;
`endif

  int total = 0, bad = 0;
  int cyc = 0, trig_cnt = 0, ack_cnt = 0, rxv_cnt = 0, busy_cnt = 0;
  logic [BW-1:0] trig_vals[$];
  int            trig_cyc[$];

  link_ctrl #(.TIMEOUT_CYCLES(100), .MAX_RETRY(2), .BUS_W(BW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .req_move(req_move), .req_btn(req_btn),
    .board_bus(board_bus), .tx_busy(tx_busy), .tx_trigger(tx_trigger), .tx_val(tx_val),
    .rx_ready(rx_ready), .rx_data(rx_data), .rx_board(rx_board),
    .rx_board_valid(rx_board_valid), .ack_ok(ack_ok), .link_busy(link_busy),
    .link_err(link_err)
`ifdef LINK_STATS_EN
    , .frames_sent(frames_sent), .retries_total(retries_total)
`endif
  );

  always #5 clk_in = ~clk_in;

  // tx serializer model plus event monitors
  assign tx_busy = (busy_cnt != 0);
  always @(negedge clk_in) begin
    cyc <= cyc + 1;
    if (tx_trigger) begin
      busy_cnt <= BUSY_CYC;
      trig_cnt <= trig_cnt + 1;
      trig_vals.push_back(tx_val);
      trig_cyc.push_back(cyc);
    end else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    if (ack_ok)         ack_cnt <= ack_cnt + 1;
    if (rx_board_valid) rxv_cnt <= rxv_cnt + 1;
  end

  task automatic wait_trig(input int target, input int budget, output bit ok);
    int n = 0;
    while (trig_cnt < target && n < budget) begin @(negedge clk_in); n++; end
    ok = (trig_cnt >= target);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    while (link_busy && n < budget) begin @(negedge clk_in); n++; end
    ok = !link_busy;
  endtask

  task automatic pulse_move();
    @(negedge clk_in); req_move = 1'b1;
    @(negedge clk_in); req_move = 1'b0;
  endtask

  task automatic pulse_rx(input logic [BW-1:0] d);
    @(negedge clk_in); rx_ready = 1'b1; rx_data = d;
    @(negedge clk_in); rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    total++; if (tx_trigger !== 1'b0)     begin bad++; $display("FAIL reset_tx_trigger got=%0b exp=0", tx_trigger); end
    total++; if (tx_val !== '0)           begin bad++; $display("FAIL reset_tx_val got=%0h exp=0", tx_val); end
    total++; if (rx_board !== '0)         begin bad++; $display("FAIL reset_rx_board got=%0h exp=0", rx_board); end
    total++; if (rx_board_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%0b exp=0", rx_board_valid); end
    total++; if (ack_ok !== 1'b0)         begin bad++; $display("FAIL reset_ack_ok got=%0b exp=0", ack_ok); end
    total++; if (link_busy !== 1'b0)      begin bad++; $display("FAIL reset_link_busy got=%0b exp=0", link_busy); end
    total++; if (link_err !== 1'b0)       begin bad++; $display("FAIL reset_link_err got=%0b exp=0", link_err); end
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_move_ack();
    int t0 = trig_cnt, a0 = ack_cnt, r0 = rxv_cnt;
    bit ok;
    board_bus = BW'(5);
    pulse_move();
    wait_trig(t0 + 1, 50, ok);
    total++; if (!ok) begin bad++; $display("FAIL move_trigger got=%0d exp=%0d", trig_cnt - t0, 1); end
    total++; if (tx_val !== BW'(5)) begin bad++; $display("FAIL move_tx_val got=%0h exp=5", tx_val); end
    repeat (60) @(negedge clk_in);
    pulse_rx(BW'(5));
    wait_idle(50, ok);
    repeat (3) @(negedge clk_in);
    total++; if (!ok || link_busy !== 1'b0) begin bad++; $display("FAIL move_link_busy got=%0b exp=0", link_busy); end
    total++; if (ack_cnt !== a0 + 1)  begin bad++; $display("FAIL move_ack_ok got=%0d exp=%0d", ack_cnt - a0, 1); end
    total++; if (trig_cnt !== t0 + 1) begin bad++; $display("FAIL move_trig_count got=%0d exp=%0d", trig_cnt - t0, 1); end
    total++; if (rxv_cnt !== r0)      begin bad++; $display("FAIL move_ack_forwarded got=%0d exp=0", rxv_cnt - r0); end
    total++; if (link_err !== 1'b0)   begin bad++; $display("FAIL move_link_err got=%0b exp=0", link_err); end
  endtask

  task automatic test_timeout();
    int t0 = trig_cnt;
    bit ok;
    board_bus = BW'(12'h123);
    pulse_move();
    wait_trig(t0 + 1, 50, ok);
    board_bus = BW'(12'h999);
    wait_trig(t0 + 3, 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL timeout_triggers got=%0d exp=%0d", trig_cnt - t0, 3); end
    wait_idle(200, ok);
    repeat (2) @(negedge clk_in);
    total++; if (link_err !== 1'b1) begin bad++; $display("FAIL timeout_link_err got=%0b exp=1", link_err); end
    total++; if (trig_vals[t0 + 1] !== BW'(12'h123) || trig_vals[t0 + 2] !== BW'(12'h123))
      begin bad++; $display("FAIL timeout_resend_val got=%0h,%0h exp=123", trig_vals[t0 + 1], trig_vals[t0 + 2]); end
    total++; if (trig_cyc[t0 + 1] - trig_cyc[t0] !== ATTEMPT || trig_cyc[t0 + 2] - trig_cyc[t0 + 1] !== ATTEMPT)
      begin bad++; $display("FAIL timeout_spacing got=%0d,%0d exp=%0d", trig_cyc[t0 + 1] - trig_cyc[t0], trig_cyc[t0 + 2] - trig_cyc[t0 + 1], ATTEMPT); end
    repeat (150) @(negedge clk_in);
    total++; if (trig_cnt !== t0 + 3) begin bad++; $display("FAIL timeout_extra_trigger got=%0d exp=%0d", trig_cnt - t0, 3); end
  endtask

  task automatic test_retry_ack();
    int t0 = trig_cnt, a0 = ack_cnt;
    bit ok;
    board_bus = BW'(8'h77);
    pulse_move();
    wait_trig(t0 + 2, 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL retry_second_trigger got=%0d exp=%0d", trig_cnt - t0, 2); end
    repeat (60) @(negedge clk_in);
    pulse_rx(BW'(8'h77));
    wait_idle(100, ok);
    repeat (3) @(negedge clk_in);
    total++; if (trig_cnt !== t0 + 2) begin bad++; $display("FAIL retry_trig_count got=%0d exp=%0d", trig_cnt - t0, 2); end
    total++; if (ack_cnt !== a0 + 1)  begin bad++; $display("FAIL retry_ack_ok got=%0d exp=%0d", ack_cnt - a0, 1); end
    total++; if (link_err !== 1'b0)   begin bad++; $display("FAIL retry_err_cleared got=%0b exp=0", link_err); end
  endtask

  task automatic test_peer_idle();
    int t0 = trig_cnt, r0 = rxv_cnt, a0 = ack_cnt, n = 0, k = 0;
    pulse_rx(BW'(12'hABC));
    total++; if (rx_board !== BW'(12'hABC)) begin bad++; $display("FAIL peer_rx_board got=%0h exp=abc", rx_board); end
    total++; if (rx_board_valid !== 1'b1)   begin bad++; $display("FAIL peer_rx_valid got=%0b exp=1", rx_board_valid); end
    while (k < 100 && !(n > 0 && !link_busy)) begin
      if (link_busy) n++;
      @(negedge clk_in); k++;
    end
    // Echo frame: LOAD + 20 SEND cycles, no WAIT_ACK.
    total++; if (n !== 21) begin bad++; $display("FAIL peer_busy_cycles got=%0d exp=21", n); end
    total++; if (trig_cnt !== t0 + 1 || trig_vals[t0] !== BW'(12'hABC))
      begin bad++; $display("FAIL peer_echo got=%0d/%0h exp=1/abc", trig_cnt - t0, trig_vals[t0]); end
    total++; if (rxv_cnt !== r0 + 1) begin bad++; $display("FAIL peer_valid_pulses got=%0d exp=1", rxv_cnt - r0); end
    repeat (30) @(negedge clk_in);
    total++; if (trig_cnt !== t0 + 1 || ack_cnt !== a0)
      begin bad++; $display("FAIL peer_no_retry got=%0d/%0d exp=1/0", trig_cnt - t0, ack_cnt - a0); end
  endtask

  task automatic test_contention();
    int t0 = trig_cnt, a0 = ack_cnt;
    bit ok;
    board_bus = BW'(8'h11);
    pulse_move();
    wait_trig(t0 + 1, 50, ok);
    repeat (25) @(negedge clk_in);
    @(negedge clk_in); req_move = 1'b1; req_btn = 1'b1; board_bus = BW'(8'h22);
    @(negedge clk_in); req_move = 1'b0;
    repeat (3) @(negedge clk_in);
    pulse_rx(BW'(8'h07));
    repeat (3) @(negedge clk_in);
    pulse_rx(BW'(8'h11));
    req_btn = 1'b0;
    wait_trig(t0 + 3, 200, ok);
    board_bus = BW'(8'h33);
    repeat (60) @(negedge clk_in);
    pulse_rx(BW'(8'h22));
    wait_trig(t0 + 4, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL cont_triggers got=%0d exp=%0d", trig_cnt - t0, 4); end
    repeat (60) @(negedge clk_in);
    pulse_rx(BW'(8'h33));
    wait_idle(100, ok);
    repeat (3) @(negedge clk_in);
    total++; if (trig_vals[t0] !== BW'(8'h11) || trig_vals[t0 + 1] !== BW'(8'h07) ||
                 trig_vals[t0 + 2] !== BW'(8'h22) || trig_vals[t0 + 3] !== BW'(8'h33))
      begin bad++; $display("FAIL cont_order got=%0h,%0h,%0h,%0h exp=11,7,22,33", trig_vals[t0], trig_vals[t0 + 1], trig_vals[t0 + 2], trig_vals[t0 + 3]); end
    total++; if (ack_cnt !== a0 + 3) begin bad++; $display("FAIL cont_acks got=%0d exp=3", ack_cnt - a0); end
    total++; if (rx_board !== BW'(8'h07)) begin bad++; $display("FAIL cont_rx_board got=%0h exp=7", rx_board); end
  endtask

  task automatic test_reset_mid_send();
    int t0 = trig_cnt;
    bit ok;
    board_bus = BW'(8'h55);
    pulse_move();
    wait_trig(t0 + 1, 50, ok);
    repeat (3) @(negedge clk_in);
    @(negedge clk_in); req_move = 1'b1; req_btn = 1'b1;
    @(negedge clk_in); req_move = 1'b0; req_btn = 1'b0; rst_in = 1'b1;
    @(negedge clk_in); rst_in = 1'b0;
    total++; if (tx_val !== '0 || rx_board !== '0)
      begin bad++; $display("FAIL rst_mid_data got=%0h/%0h exp=0/0", tx_val, rx_board); end
    total++; if (link_busy !== 1'b0 || link_err !== 1'b0 || tx_trigger !== 1'b0)
      begin bad++; $display("FAIL rst_mid_flags got=%0b%0b%0b exp=000", link_busy, link_err, tx_trigger); end
    repeat (200) @(negedge clk_in);
    total++; if (trig_cnt !== t0 + 1) begin bad++; $display("FAIL rst_mid_pending got=%0d exp=%0d", trig_cnt - t0, 1); end
  endtask

  initial begin
    test_reset();
    test_move_ack();
    test_timeout();
    test_retry_ack();
    test_peer_idle();
    test_contention();
    test_reset_mid_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
